// File: rtl/b_resp_router_1_2.sv
// Write-response return path for the 2-master write interconnect.
// Tracks AW ownership in an in-order FIFO and steers each slave B response to its owner.
module b_resp_router_1_2 #(
  parameter int Depth     = 4,
  parameter int Ptr_width = 2
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 AW_Sel_Master,
  input  logic                 AW_Handshake,
  input  logic [1:0]           M_AXI_bresp,
  input  logic                 M_AXI_bvalid,
  output logic                 M_AXI_bready,
  output logic [1:0]           S00_AXI_bresp,
  output logic                 S00_AXI_bvalid,
  input  logic                 S00_AXI_bready,
  output logic [1:0]           S01_AXI_bresp,
  output logic                 S01_AXI_bvalid,
  input  logic                 S01_AXI_bready,
  output logic                 Outstanding_Full,
  output logic [Ptr_width:0]   Outstanding_Count,
  output logic                 Overflow_Err
);

  localparam logic [Ptr_width:0] FullCount = (Ptr_width + 1)'(Depth);

  logic                 r_mem [Depth];
  logic [Ptr_width-1:0] r_wr_ptr;
  logic [Ptr_width-1:0] r_rd_ptr;
  logic [Ptr_width:0]   r_count;
  logic                 r_overflow;

  logic w_empty;
  logic w_full;
  logic w_head;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCount);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_pop   = M_AXI_bvalid & M_AXI_bready;
  // A full tracker can still accept a new owner when the head retires in the same cycle.
  assign w_push  = AW_Handshake & (~w_full | w_pop);

  assign Outstanding_Full  = w_full;
  assign Outstanding_Count = r_count;
  assign Overflow_Err      = r_overflow;
  assign S00_AXI_bresp     = M_AXI_bresp;
  assign S01_AXI_bresp     = M_AXI_bresp;

  // bvalid depends only on the slave bvalid and the head owner, never on any master bready.
  always_comb begin
    M_AXI_bready   = 1'b0;
    S00_AXI_bvalid = 1'b0;
    S01_AXI_bvalid = 1'b0;
    if (!w_empty) begin
      if (w_head) begin
        S01_AXI_bvalid = M_AXI_bvalid;
        M_AXI_bready   = S01_AXI_bready;
      end else begin
        S00_AXI_bvalid = M_AXI_bvalid;
        M_AXI_bready   = S00_AXI_bready;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= AW_Sel_Master;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // Sticky until reset so software can see that a write was lost.
      if (AW_Handshake && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
